// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer
// Sequences a WIDTH-bit bidirectional shift register for two requesters.
// A round-robin arbiter picks one requester in IDLE, latches its direction,
// clamped bit count and serial pattern, then drives sel/d0/d1 for exactly
// that many clocks, one bit per clock. Bit 0 of the pattern goes out first.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous active-low reset
//   req0, req1            level requests
//   req0_dir, req1_dir    0: shift via d0 (sel=10), 1: shift via d1 (sel=01)
//   req0_len, req1_len    bits to shift (0 = no-op, >WIDTH clamped to WIDTH)
//   req0_data, req1_data  serial pattern, bit 0 first
//   gnt                   one-hot grant, one-cycle pulse
//   done                  one-hot completion, one-cycle pulse
//   busy                  high whenever the sequencer is not idle
//   sel                   register control: 00 hold, 01 via d1, 10 via d0
//   d0, d1                serial data to the register
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             req0_dir,
  input  logic             req1_dir,
  input  logic [CW-1:0]    req0_len,
  input  logic [CW-1:0]    req1_len,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [1:0]       sel,
  output logic             d0,
  output logic             d1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             win;
  logic [CW-1:0]    len_sel;

  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] len);
    if (int'(len) > WIDTH) return CW'(WIDTH);
    return len;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    gnt_d   = 2'b00;
    win     = 1'b0;
    len_sel = '0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A lone request wins outright; the pointer only breaks ties.
          win     = (req0 && req1) ? ptr_q : req1;
          len_sel = clamp_len(win ? req1_len : req0_len);
          owner_d = win;
          dir_d   = win ? req1_dir : req0_dir;
          cnt_d   = len_sel;
          sreg_d  = win ? req1_data : req0_data;
          gnt_d   = win ? 2'b10 : 2'b01;
          // A zero-length transfer still spends one SHIFT cycle with sel held
          // at 00, so its grant and completion land on separate cycles.
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q >> 1;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      gnt_q   <= gnt_d;
    end
  end

  // Output decode from registered state only
  always_comb begin
    gnt  = gnt_q;
    busy = (state_q != IDLE);
    done = 2'b00;
    sel  = 2'b00;
    d0   = 1'b0;
    d1   = 1'b0;
    if (state_q == DONE) done = owner_q ? 2'b10 : 2'b01;
    if (state_q == SHIFT && cnt_q != '0) begin
      if (dir_q) begin
        sel = 2'b01;
        d1  = sreg_q[0];
      end else begin
        sel = 2'b10;
        d0  = sreg_q[0];
      end
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Testbench for shift_register_sequencer: directed transactions with a
// per-cycle expected-output queue consumed by an independent monitor.
module tb_shift_register_sequencer;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic             req0_dir, req1_dir;
  logic [CW-1:0]    req0_len, req1_len;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic [1:0]       gnt, done;
  logic             busy;
  logic [1:0]       sel;
  logic             d0, d1;

  shift_register_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .req0_dir  (req0_dir),
    .req1_dir  (req1_dir),
    .req0_len  (req0_len),
    .req1_len  (req1_len),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .sel       (sel),
    .d0        (d0),
    .d1        (d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected busy cycle: {gnt, done, sel, d0, d1}; gap is the number of
  // idle cycles required before it (-1 = don't care).
  typedef struct {
    logic [7:0] vec;
    int         gap;
    string      nm;
  } rec_t;

  rec_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idle_run = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input int who, input bit dir, input int len,
                          input logic [3:0] data, input int gap, input string nm);
    rec_t       r;
    int         l;
    int         ncyc;
    logic [1:0] oh;
    logic [1:0] s;
    logic       b0, b1;
    l    = (len > 4) ? 4 : len;
    ncyc = (l == 0) ? 1 : l;
    oh   = (who == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < ncyc; k++) begin
      s  = (l == 0) ? 2'b00 : (dir ? 2'b01 : 2'b10);
      b0 = (l != 0 && !dir) ? data[k] : 1'b0;
      b1 = (l != 0 &&  dir) ? data[k] : 1'b0;
      r.vec = {(k == 0) ? oh : 2'b00, 2'b00, s, b0, b1};
      r.gap = (k == 0) ? gap : -1;
      r.nm  = $sformatf("%s_c%0d", nm, k);
      expq.push_back(r);
    end
    r.vec = {2'b00, oh, 2'b00, 1'b0, 1'b0};
    r.gap = -1;
    r.nm  = $sformatf("%s_done", nm);
    expq.push_back(r);
  endtask

  task automatic check_idle(input string nm);
    logic [8:0] obs;
    obs = {gnt, done, busy, sel, d0, d1};
    n_cmp++;
    if (obs !== 9'b0) begin
      n_bad++;
      $display("FAIL %s: got {gnt,done,busy,sel,d0,d1}=%b required 000000000", nm, obs);
    end
  endtask

  task automatic wait_grants(input int count, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < 60 && seen < count; i++) begin
      tick();
      if (gnt != 2'b00) seen++;
    end
    if (seen < count) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_grant_timeout: got %0d grants required %0d", nm, seen, count);
    end
  endtask

  task automatic drain(input string nm);
    bool_loop: for (int i = 0; i < 60; i++) begin
      if (expq.size() == 0 && !busy) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_drain_timeout: got %0d pending busy=%b required 0 pending busy=0",
             nm, expq.size(), busy);
    expq.delete();
  endtask

  // Monitor: consumes one expected record per busy cycle.
  initial begin
    rec_t       r;
    logic [7:0] obs;
    forever begin
      @(negedge clk);
      obs = {gnt, done, sel, d0, d1};
      if (busy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_busy: got outputs %b required idle", obs);
        end else begin
          r = expq.pop_front();
          n_cmp++;
          if (obs !== r.vec) begin
            n_bad++;
            $display("FAIL %s: got {gnt,done,sel,d0,d1}=%b required %b", r.nm, obs, r.vec);
          end
          if (r.gap >= 0) begin
            n_cmp++;
            if (idle_run != r.gap) begin
              n_bad++;
              $display("FAIL %s_gap: got %0d idle cycles required %0d", r.nm, idle_run, r.gap);
            end
          end
        end
        idle_run = 0;
      end else begin
        n_cmp++;
        if (obs !== 8'h00) begin
          n_bad++;
          $display("FAIL idle_outputs: got {gnt,done,sel,d0,d1}=%b required 00000000", obs);
        end
        idle_run++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held while requester 0 is asking
    rst       = 1'b0;
    req0      = 1'b1;
    req1      = 1'b0;
    req0_dir  = 1'b0;
    req1_dir  = 1'b0;
    req0_len  = 3'd4;
    req1_len  = 3'd0;
    req0_data = 4'b1011;
    req1_data = 4'b0000;
    tick();
    tick();
    check_idle("reset_hold_req0");
    req0 = 1'b0;
    rst  = 1'b1;
    tick();

    // Single transfer via d0: d0 = 1,1,0,1
    req0 = 1'b1; req0_dir = 1'b0; req0_len = 3'd4; req0_data = 4'b1011;
    push_txn(0, 1'b0, 4, 4'b1011, -1, "single");
    wait_grants(1, "single");
    req0 = 1'b0;
    drain("single");

    // Zero-length transfer on requester 1
    req1 = 1'b1; req1_dir = 1'b0; req1_len = 3'd0; req1_data = 4'b1111;
    push_txn(1, 1'b0, 0, 4'b1111, -1, "len0");
    wait_grants(1, "len0");
    req1 = 1'b0;
    drain("len0");

    // len=7 clamped to 4 shifts via d1: d1 = 0,1,1,0
    req0 = 1'b1; req0_dir = 1'b1; req0_len = 3'd7; req0_data = 4'b0110;
    push_txn(0, 1'b1, 7, 4'b0110, -1, "len7");
    wait_grants(1, "len7");
    req0 = 1'b0;
    drain("len7");

    // Contention from reset: grants alternate 01,10,01,10 every 4 cycles
    rst = 1'b0;
    req0 = 1'b1; req0_dir = 1'b1; req0_len = 3'd2; req0_data = 4'b0010;
    req1 = 1'b1; req1_dir = 1'b1; req1_len = 3'd2; req1_data = 4'b0001;
    push_txn(0, 1'b1, 2, 4'b0010, -1, "cont_a0");
    push_txn(1, 1'b1, 2, 4'b0001,  1, "cont_a1");
    push_txn(0, 1'b1, 2, 4'b0010,  1, "cont_b0");
    push_txn(1, 1'b1, 2, 4'b0001,  1, "cont_b1");
    #1;
    check_idle("reset_hold_both");
    tick();
    rst = 1'b1;
    wait_grants(4, "cont");
    req0 = 1'b0;
    req1 = 1'b0;
    drain("cont");

    // Reset during the 3rd SHIFT cycle, then replay from bit 0
    req0 = 1'b1; req0_dir = 1'b0; req0_len = 3'd4; req0_data = 4'b1001;
    push_txn(0, 1'b0, 4, 4'b1001, -1, "pre_reset");
    wait_grants(1, "pre_reset");
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    check_idle("reset_mid_shift");
    expq.delete();
    push_txn(0, 1'b0, 4, 4'b1001, -1, "replay");
    tick();
    rst = 1'b1;
    wait_grants(1, "replay");
    req0 = 1'b0;
    drain("replay");

    // req1 rising during req0's SHIFT waits for the IDLE edge after done
    req0 = 1'b1; req0_dir = 1'b1; req0_len = 3'd3; req0_data = 4'b0101;
    push_txn(0, 1'b1, 3, 4'b0101, -1, "owner");
    wait_grants(1, "owner");
    req0 = 1'b0;
    tick();
    req1 = 1'b1; req1_dir = 1'b0; req1_len = 3'd2; req1_data = 4'b0011;
    push_txn(1, 1'b0, 2, 4'b0011, 1, "late");
    wait_grants(1, "late");
    req1 = 1'b0;
    drain("late");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
